// File: rtl/user_io_bank.sv
// Wishbone-mapped GPIO bank: software- or LA-driven pads, synchronised inputs,
// and edge-detect interrupts with write-1-to-clear status.
module user_io_bank #(
    parameter int unsigned N_IO        = 8,
    parameter logic [31:0] BASE_ADR    = 32'h3000_0000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_ni,
    input  logic            wbs_stb_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_adr_i,
    input  logic [31:0]     wbs_dat_i,
    output logic            wbs_ack_o,
    output logic [31:0]     wbs_dat_o,
    input  logic [N_IO-1:0] io_in,
    output logic [N_IO-1:0] io_out,
    output logic [N_IO-1:0] io_oeb,
    input  logic [N_IO-1:0] la_data_in,
    input  logic [N_IO-1:0] la_oenb,
    output logic [N_IO-1:0] la_data_out,
    output logic            irq_o
);

    localparam int unsigned DW = 32;

    localparam logic [7:0] OFF_OUT     = 8'h00;
    localparam logic [7:0] OFF_OEB     = 8'h04;
    localparam logic [7:0] OFF_IN      = 8'h08;
    localparam logic [7:0] OFF_RISE_EN = 8'h0C;
    localparam logic [7:0] OFF_FALL_EN = 8'h10;
    localparam logic [7:0] OFF_STATUS  = 8'h14;
    localparam logic [7:0] OFF_MODE    = 8'h18;

    // Software-visible registers
    logic [N_IO-1:0] out_q;
    logic [N_IO-1:0] oeb_q;
    logic [N_IO-1:0] rise_en_q;
    logic [N_IO-1:0] fall_en_q;
    logic [N_IO-1:0] status_q;
    logic [N_IO-1:0] mode_q;

    // Input path
    logic [N_IO-1:0] sync_q [SYNC_STAGES];
    logic [N_IO-1:0] in_s;
    logic [N_IO-1:0] in_d_q;

    // Bus response
    logic            ack_q;
    logic [DW-1:0]   dat_q;

    // Combinational decode
    logic            req;
    logic            acc;
    logic            wr;
    logic [7:0]      off;
    logic [N_IO-1:0] wmask;
    logic [N_IO-1:0] wdata;
    logic [N_IO-1:0] events;
    logic [N_IO-1:0] w1c;
    logic            wr_out;
    logic            wr_oeb;
    logic            wr_rise;
    logic            wr_fall;
    logic            wr_mode;
    logic [DW-1:0]   rdata;

    logic            unused_bits;
    assign unused_bits = ^{wbs_dat_i, wbs_sel_i};

    // Byte-lane write mask, one select bit per 8 pads
    for (genvar g = 0; g < N_IO; g++) begin : g_wmask
        assign wmask[g] = wbs_sel_i[g / 8];
    end

    assign off   = wbs_adr_i[7:0];
    assign wdata = wbs_dat_i[N_IO-1:0];
    assign in_s  = sync_q[SYNC_STAGES-1];

    // A request is accepted only when the previous cycle did not ack
    assign req = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:8] == BASE_ADR[31:8]);
    assign acc = req && !ack_q;
    assign wr  = acc && wbs_we_i;

    assign events = (in_s & ~in_d_q & rise_en_q) | (~in_s & in_d_q & fall_en_q);

    // Register write strobes
    always_comb begin
        wr_out  = 1'b0;
        wr_oeb  = 1'b0;
        wr_rise = 1'b0;
        wr_fall = 1'b0;
        wr_mode = 1'b0;
        w1c     = '0;
        if (wr) begin
            case (off)
                OFF_OUT:     wr_out  = 1'b1;
                OFF_OEB:     wr_oeb  = 1'b1;
                OFF_RISE_EN: wr_rise = 1'b1;
                OFF_FALL_EN: wr_fall = 1'b1;
                OFF_STATUS:  w1c     = wdata & wmask;
                OFF_MODE:    wr_mode = 1'b1;
                default:     ;
            endcase
        end
    end

    // Read mux; unmapped offsets read 0
    always_comb begin
        rdata = '0;
        case (off)
            OFF_OUT:     rdata = DW'(out_q);
            OFF_OEB:     rdata = DW'(oeb_q);
            OFF_IN:      rdata = DW'(in_s);
            OFF_RISE_EN: rdata = DW'(rise_en_q);
            OFF_FALL_EN: rdata = DW'(fall_en_q);
            OFF_STATUS:  rdata = DW'(status_q);
            OFF_MODE:    rdata = DW'(mode_q);
            default:     rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= acc;
            dat_q <= (acc && !wbs_we_i) ? rdata : '0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            out_q     <= '0;
            oeb_q     <= '1;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            mode_q    <= '0;
        end else begin
            if (wr_out)  out_q     <= (out_q     & ~wmask) | (wdata & wmask);
            if (wr_oeb)  oeb_q     <= (oeb_q     & ~wmask) | (wdata & wmask);
            if (wr_rise) rise_en_q <= (rise_en_q & ~wmask) | (wdata & wmask);
            if (wr_fall) fall_en_q <= (fall_en_q & ~wmask) | (wdata & wmask);
            if (wr_mode) mode_q    <= (mode_q    & ~wmask) | (wdata & wmask);
            // A new event outranks a simultaneous clear
            status_q <= (status_q & ~w1c) | events;
        end
    end

    // Pad input synchroniser plus one-cycle delay for edge detection
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            in_d_q <= '0;
        end else begin
            sync_q[0] <= io_in;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            in_d_q <= in_s;
        end
    end

    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = dat_q;
    assign io_out      = (mode_q & la_data_in) | (~mode_q & out_q);
    assign io_oeb      = (mode_q & la_oenb)    | (~mode_q & oeb_q);
    assign la_data_out = in_s;
    assign irq_o       = |(status_q & (rise_en_q | fall_en_q));

endmodule
